// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: E-stage controller <-> multiply/divide unit handshake and data.
interface mul_div_unit_if;
    logic [3:0]  sel_MDU;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] out;
    modport master (output sel_MDU, A, B, flush, input start, busy, out);
    modport slave  (input sel_MDU, A, B, flush, output start, busy, out);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO multiply/divide unit; result computed at accept, committed after a fixed 5/10-cycle delay.
module mul_div_unit (
    input  logic clk,
    input  logic reset,
    mul_div_unit_if.slave mdu
);
    logic [31:0] hi, lo, p_hi, p_lo;
    logic [3:0]  cnt;
    logic        busy;
    logic        is_md, is_div, sgn;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u, prod;
    logic [31:0] ua, ub, d, q_mag, r_mag, q, r;
    always_comb begin
        is_md  = mdu.sel_MDU[3:2] == 2'b00;
        is_div = mdu.sel_MDU[1];
        sgn    = !mdu.sel_MDU[0];
        prod_s = $signed(mdu.A) * $signed(mdu.B);
        prod_u = {32'b0, mdu.A} * {32'b0, mdu.B};
        prod   = sgn ? prod_s : prod_u;
        // signed division done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
        ua     = (sgn && mdu.A[31]) ? -mdu.A : mdu.A;
        ub     = (sgn && mdu.B[31]) ? -mdu.B : mdu.B;
        d      = (ub == 32'b0) ? 32'd1 : ub;
        q_mag  = ua / d;
        r_mag  = ua % d;
        q      = (sgn && (mdu.A[31] ^ mdu.B[31])) ? -q_mag : q_mag;
        r      = (sgn && mdu.A[31]) ? -r_mag : r_mag;
    end
    assign mdu.start = is_md && !busy && !mdu.flush && !reset;
    assign mdu.busy  = busy;
    assign mdu.out   = reset ? 32'b0 : mdu.sel_MDU == 4'd4 ? hi : mdu.sel_MDU == 4'd5 ? lo : 32'b0;
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            p_hi <= '0;
            p_lo <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (mdu.start) begin
            // divide by zero parks the current HI/LO as the pending result so commit is a no-op
            p_hi <= !is_div ? prod[63:32] : (mdu.B == 32'b0) ? hi : r;
            p_lo <= !is_div ? prod[31:0]  : (mdu.B == 32'b0) ? lo : q;
            cnt  <= is_div ? 4'd10 : 4'd5;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == 4'd1) begin
                hi   <= p_hi;
                lo   <= p_lo;
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (!mdu.flush && mdu.sel_MDU == 4'd6) begin
            hi <= mdu.A;
        end else if (!mdu.flush && mdu.sel_MDU == 4'd7) begin
            lo <= mdu.A;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed scenarios plus random ops checked against a cycle-level arithmetic model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset;
    int total = 0, bad = 0;
    mul_div_unit_if mdu ();
    mul_div_unit dut (.clk(clk), .reset(reset), .mdu(mdu.slave));
    always #5 clk = ~clk;

    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    int          m_rem = 0;
    bit          m_pvalid = 0;
    logic [31:0] last_out;
    logic        last_start, last_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock cycle: drive, check combinational/registered outputs, then advance the model past the edge
    task automatic cycle(input logic r, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, input logic fl);
        bit md, st;
        longint sa, sb, p, qq, rr;
        longint unsigned uu;
        @(posedge clk);
        #1;
        reset = r; mdu.sel_MDU = sel; mdu.A = a; mdu.B = b; mdu.flush = fl;
        #1;
        md = sel <= 4'd3;
        st = md && m_rem == 0 && !fl && !r;
        last_out = mdu.out; last_start = mdu.start; last_busy = mdu.busy;
        check("start", {31'b0, mdu.start}, {31'b0, st});
        check("busy", {31'b0, mdu.busy}, {31'b0, m_rem > 0});
        check("out", mdu.out, r ? 32'b0 : sel == 4'd4 ? m_hi : sel == 4'd5 ? m_lo : 32'b0);
        if (r) begin
            m_hi = 0; m_lo = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pvalid) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (st) begin
            sa = $signed(a); sb = $signed(b);
            m_pvalid = 1;
            case (sel)
                4'd0: begin p = sa * sb; {m_phi, m_plo} = p; end
                4'd1: begin uu = longint'(a) * longint'(b); {m_phi, m_plo} = uu; end
                4'd2: if (b == 0) m_pvalid = 0; else begin qq = sa / sb; rr = sa % sb; m_plo = qq[31:0]; m_phi = rr[31:0]; end
                default: if (b == 0) m_pvalid = 0; else begin m_plo = a / b; m_phi = a % b; end
            endcase
            m_rem = sel[1] ? 10 : 5;
        end else if (!fl && sel == 4'd6) m_hi = a;
        else if (!fl && sel == 4'd7) m_lo = a;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 4'd15, $urandom, $urandom, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; mdu.sel_MDU = 4'd15; mdu.A = 0; mdu.B = 0; mdu.flush = 0;
        cycle(1, 4'd4, 0, 0, 0);
        check("rst_out", last_out, 32'h0);
        cycle(0, 4'd5, 0, 0, 0);
        check("rst_lo", last_out, 32'h0);
        // mult -2 * 3
        cycle(0, 4'd0, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_start", {31'b0, last_start}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 4'd15, 0, 0, 0);
            check("mult_busy", {31'b0, last_busy}, 32'd1);
        end
        cycle(0, 4'd4, 0, 0, 0);
        check("mult_busy_end", {31'b0, last_busy}, 32'd0);
        check("mult_hi", last_out, 32'hFFFF_FFFF);
        cycle(0, 4'd5, 0, 0, 0);
        check("mult_lo", last_out, 32'hFFFF_FFFA);
        // multu with mflo during busy
        cycle(0, 4'd1, 32'hFFFF_FFFF, 32'd2, 0);
        idle(2);
        cycle(0, 4'd5, 0, 0, 0);
        check("multu_old_lo", last_out, 32'hFFFF_FFFA);
        idle(2);
        cycle(0, 4'd4, 0, 0, 0);
        check("multu_hi", last_out, 32'h1);
        cycle(0, 4'd5, 0, 0, 0);
        check("multu_lo", last_out, 32'hFFFF_FFFE);
        // div -7 / 2, second div ignored
        cycle(0, 4'd2, 32'hFFFF_FFF9, 32'd2, 0);
        idle(3);
        cycle(0, 4'd2, 32'd7, 32'd1, 0);
        check("div_ignored", {31'b0, last_start}, 32'd0);
        idle(6);
        cycle(0, 4'd5, 0, 0, 0);
        check("div_lo", last_out, 32'hFFFF_FFFD);
        cycle(0, 4'd4, 0, 0, 0);
        check("div_hi", last_out, 32'hFFFF_FFFF);
        // divide by zero then overflow
        cycle(0, 4'd6, 32'h1234, 0, 0);
        cycle(0, 4'd7, 32'h5678, 0, 0);
        cycle(0, 4'd3, 32'd5, 32'd0, 0);
        idle(10);
        cycle(0, 4'd4, 0, 0, 0);
        check("div0_hi", last_out, 32'h1234);
        cycle(0, 4'd5, 0, 0, 0);
        check("div0_lo", last_out, 32'h5678);
        cycle(0, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(10);
        cycle(0, 4'd5, 0, 0, 0);
        check("ovf_lo", last_out, 32'h8000_0000);
        cycle(0, 4'd4, 0, 0, 0);
        check("ovf_hi", last_out, 32'h0);
        // flush
        cycle(0, 4'd0, 32'd3, 32'd3, 1);
        check("flush_start", {31'b0, last_start}, 32'd0);
        cycle(0, 4'd7, 32'hDEAD, 0, 1);
        check("flush_busy", {31'b0, last_busy}, 32'd0);
        cycle(0, 4'd5, 0, 0, 0);
        check("flush_lo", last_out, 32'h8000_0000);
        // reset in third busy cycle
        cycle(0, 4'd2, 32'd100, 32'd7, 0);
        idle(2);
        cycle(1, 4'd15, 0, 0, 0);
        cycle(0, 4'd4, 0, 0, 0);
        check("rst_busy", {31'b0, last_busy}, 32'd0);
        check("rst_hi", last_out, 32'h0);
        // back-to-back
        cycle(0, 4'd3, 32'd100, 32'd7, 0);
        idle(10);
        cycle(0, 4'd0, 32'd6, 32'd7, 0);
        check("b2b_start", {31'b0, last_start}, 32'd1);
        idle(5);
        cycle(0, 4'd5, 0, 0, 0);
        check("b2b_lo", last_out, 32'd42);
        // random traffic
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 99) == 0, 4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
                  $urandom_range(0, 7) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port sel_MDU, input, 4 bits: operation select from the E-stage controller; mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7, none=15; other values are treated as none.
REQ-004 The block SHALL have port A, input, 32 bits: rs operand (multiplicand, dividend, or mthi/mtlo data).
REQ-005 The block SHALL have port B, input, 32 bits: rt operand (multiplier or divisor).
REQ-006 The block SHALL have port flush, input, 1 bit: when high, an exception/eret is in progress and the current sel_MDU is suppressed.
REQ-007 The block SHALL have port start, output, 1 bit: combinational; high when a multiply or divide is accepted this cycle.
REQ-008 The block SHALL have port busy, output, 1 bit: registered; high while a multiply or divide is in flight.
REQ-009 The block SHALL have port out, output, 32 bits: combinational read data; HI for mfhi, LO for mflo, 0 otherwise.

Function
REQ-010 start SHALL equal (sel_MDU in {0,1,2,3}) AND NOT busy AND NOT flush AND NOT reset.
REQ-011 On an edge with start high, the block SHALL capture the full result into internal pending registers. Pending HI/LO are as follows:
- mult/multu: {HI,LO} = 64-bit signed or unsigned product A*B.
- div/divu: LO = quotient, HI = remainder.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-012 On the same edge, the block SHALL load the cycle counter with 5 for mult/multu or 10 for div/divu, and set busy.
REQ-013 While busy, the counter SHALL decrement once per cycle. On the edge where the counter equals 1, the block SHALL copy pending to HI/LO, clear busy, and clear the counter.
REQ-014 Latency: with start in cycle T, busy SHALL be high in cycles T+1..T+5 (mult) or T+1..T+10 (div). The new HI/LO SHALL be visible on out from cycle T+6 or T+11 respectively.
REQ-015 mthi SHALL write A into HI, and mtlo SHALL write A into LO, at the edge, when NOT busy and NOT flush. Both take effect in the next cycle.
REQ-016 mthi/mtlo asserted while busy SHALL be ignored; HI/LO SHALL be unchanged.
REQ-017 Any md op asserted while busy SHALL be ignored: start stays 0, and the in-flight result and counter are undisturbed.
REQ-018 mfhi/mflo SHALL read committed HI/LO only, never pending values, regardless of busy.
REQ-019 flush high SHALL prevent start and mt writes in that cycle. It SHALL NOT abort an operation already in flight.
REQ-020 div/divu with B=0 SHALL run the full 10 cycles and leave HI/LO unchanged at completion.
REQ-021 div with A=0x80000000 and B=0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-022 The block SHALL support back-to-back operation: a new md op in the cycle busy first reads 0 SHALL be accepted (start=1).
REQ-023 sel_MDU=none SHALL cause no state change.

Reset
REQ-024 On an edge with reset high, the block SHALL clear HI, LO, the pending registers, the counter and busy to 0. start and out SHALL read 0 in the reset cycle.
REQ-025 Reset SHALL take priority over every other input. Reset during busy SHALL abort the operation with no HI/LO update.

Verification
REQ-026 mult case: reset, then mult with A=0xFFFFFFFE (-2), B=3 -> start=1 in T; busy=1 for T+1..T+5; in T+6, mfhi out=0xFFFFFFFF and mflo out=0xFFFFFFFA.
REQ-027 multu and mflo-during-busy case: multu with A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE after 5 busy cycles; mflo issued in T+3 returns the prior LO value.
REQ-028 div and ignored-start case: div with A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF. A second div issued in T+4 gets start=0 and does not change the result.
REQ-029 Divide-by-zero and overflow case: mthi 0x1234, mtlo 0x5678, then divu with B=0 -> after 10 busy cycles HI=0x1234 and LO=0x5678. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-030 flush case: mult asserted with flush=1 -> start=0, busy stays 0, HI/LO unchanged. mtlo with flush=1 -> LO unchanged.
REQ-031 Reset and back-to-back case: reset asserted in the third busy cycle of a div -> busy=0 and HI=LO=0 next cycle. Separately, a mult issued in the first cycle with busy=0 after a div completes is accepted.
